run_detector: RTL and testbench

//  Parametrised, binary-encoded successor to the lab's two-in-a-row sequence FSM.

---
 rtl/run_detector_pkg.sv | 30 +++
 rtl/run_detector_if.sv | 34 +++
 rtl/run_detector_sat_counter.sv | 29 ++
 rtl/run_detector.sv | 76 +++++++
 tb/tb_run_detector.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/run_detector_pkg.sv
// rtl/run_detector_pkg.sv - shared mode encodings, state constants and helpers for run_detector
//
// Provides the mode_t field type and the polarity filter used by z and the hit logic.
package run_detector_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_EITHER = 2'b00;
    localparam mode_t MODE_ONES   = 2'b01;
    localparam mode_t MODE_ZEROS  = 2'b10;
    localparam mode_t MODE_OFF    = 2'b11;

    // Value of the valid bit: IDLE before the first sample, RUN afterwards.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Returns 1 when a run of bit value b is allowed to signal under mode m.
    function automatic logic allow(input mode_t m, input logic b);
        logic a;
        a = 1'b0;
        case (m)
            MODE_EITHER: a = 1'b1;
            MODE_ONES:   a = b;
            MODE_ZEROS:  a = ~b;
            default:     a = 1'b0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/run_detector_if.sv
// rtl/run_detector_if.sv - control/status bundle between the front end and run_detector
//
// Signals:
//   en, clear, w, mode      front end -> detector
//   z, state, run_len, hits detector -> display logic
// Modports: master (front end / bench), slave (run_detector).
interface run_detector_if #(
    parameter int RUN_LEN = 2,
    parameter int HIT_W   = 8
);
    import run_detector_pkg::*;

    localparam int CNT_W = $clog2(RUN_LEN + 1);

    logic             en;
    logic             clear;
    logic             w;
    mode_t            mode;
    logic             z;
    logic [CNT_W+1:0] state;
    logic [CNT_W-1:0] run_len;
    logic [HIT_W-1:0] hits;

    modport master (
        output en, clear, w, mode,
        input  z, state, run_len, hits
    );

    modport slave (
        input  en, clear, w, mode,
        output z, state, run_len, hits
    );

endinterface

// File: rtl/run_detector_sat_counter.sv
// rtl/run_detector_sat_counter.sv - saturating up-counter with async reset and sync clear
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   clear  synchronous clear, wins over inc
//   inc    add one unless already at all-ones
//   count  current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_detector.sv
// rtl/run_detector.sv - flags RUN_LEN consecutive equal samples of w, counts detection entries
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    run_detector_if.slave: en/clear/w/mode in; z/state/run_len/hits out
// State is {valid, last, count}; z is Moore on that state, gated by the live mode.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int HIT_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    run_detector_if.slave  bus
);

    localparam int CNT_W = $clog2(RUN_LEN + 1);

    generate
        if (RUN_LEN < 2) begin : g_bad_run_len
            $error("run_detector: RUN_LEN must be >= 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] RUN_PRE = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [0:0]       valid;
    logic             last;
    logic [CNT_W-1:0] count;
    logic             same;
    logic             hit_inc;

    assign same = (bus.w == last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= ST_IDLE;
            last  <= 1'b0;
            count <= '0;
        end else if (bus.clear) begin
            valid <= ST_IDLE;
            last  <= 1'b0;
            count <= '0;
        end else if (bus.en) begin
            if ((valid == ST_IDLE) || !same) begin
                valid <= ST_RUN;
                last  <= bus.w;
                count <= ONE;
            end else if (count != RUN_MAX) begin
                count <= count + ONE;
            end
        end
    end

    // Only the edge that completes a run counts; a saturated run adds nothing
    // because count is already RUN_MAX, not RUN_PRE.
    assign hit_inc = bus.en && !bus.clear && (valid == ST_RUN) && same &&
                     (count == RUN_PRE) && allow(bus.mode, bus.w);

    sat_counter #(.W(HIT_W)) u_hits (
        .clk   (clk),
        .rst_n (reset),
        .clear (bus.clear),
        .inc   (hit_inc),
        .count (bus.hits)
    );

    assign bus.z       = (valid == ST_RUN) && (count == RUN_MAX) && allow(bus.mode, last);
    assign bus.state   = {valid, last, count};
    assign bus.run_len = count;

endmodule

// File: tb/tb_run_detector.sv
// tb/tb_run_detector.sv - scoreboard bench for run_detector across three parameter sets
module tb_run_detector;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    run_detector_if #(.RUN_LEN(2), .HIT_W(8)) b0 ();
    run_detector_if #(.RUN_LEN(4), .HIT_W(8)) b1 ();
    run_detector_if #(.RUN_LEN(2), .HIT_W(2)) b2 ();

    run_detector #(.RUN_LEN(2), .HIT_W(8)) d0 (.clk(clk), .reset(rst_n), .bus(b0));
    run_detector #(.RUN_LEN(4), .HIT_W(8)) d1 (.clk(clk), .reset(rst_n), .bus(b1));
    run_detector #(.RUN_LEN(2), .HIT_W(2)) d2 (.clk(clk), .reset(rst_n), .bus(b2));

    typedef struct {
        int         k;
        logic       z;
        logic [7:0] st;
        logic [7:0] rl;
        logic [7:0] h;
    } exp_t;

    exp_t sbq[$];

    int tests = 0;
    int fails = 0;

    int RL[3] = '{2, 4, 2};
    int HM[3] = '{255, 255, 3};
    int CW[3] = '{2, 3, 2};

    int mv[3];
    int ml[3];
    int mc[3];
    int mh[3];
    logic [1:0] mm[3];

    function automatic int allow_m(input logic [1:0] m, input int b);
        case (m)
            2'b00:   return 1;
            2'b01:   return b;
            2'b10:   return (b == 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic en, input logic clr, input logic w, input logic [1:0] m);
        case (k)
            0: begin b0.en = en; b0.clear = clr; b0.w = w; b0.mode = m; end
            1: begin b1.en = en; b1.clear = clr; b1.w = w; b1.mode = m; end
            default: begin b2.en = en; b2.clear = clr; b2.w = w; b2.mode = m; end
        endcase
        mm[k] = m;
    endtask

    task automatic get_obs(input int k, output logic z, output logic [7:0] st,
                           output logic [7:0] rl, output logic [7:0] h);
        case (k)
            0: begin z = b0.z; st = 8'(b0.state); rl = 8'(b0.run_len); h = 8'(b0.hits); end
            1: begin z = b1.z; st = 8'(b1.state); rl = 8'(b1.run_len); h = 8'(b1.hits); end
            default: begin z = b2.z; st = 8'(b2.state); rl = 8'(b2.run_len); h = 8'(b2.hits); end
        endcase
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        int s;
        s = (mv[k] << (CW[k] + 1)) | (ml[k] << CW[k]) | mc[k];
        e.k  = k;
        e.z  = (mv[k] != 0) && (mc[k] == RL[k]) && (allow_m(mm[k], ml[k]) != 0);
        e.st = 8'(s);
        e.rl = 8'(mc[k]);
        e.h  = 8'(mh[k]);
        sbq.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        logic z;
        logic [7:0] st, rl, h;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
            return;
        end
        e = sbq.pop_front();
        get_obs(e.k, z, st, rl, h);
        chk($sformatf("%s.k%0d.z", tag, e.k), 8'(z), 8'(e.z));
        chk($sformatf("%s.k%0d.state", tag, e.k), st, e.st);
        chk($sformatf("%s.k%0d.run_len", tag, e.k), rl, e.rl);
        chk($sformatf("%s.k%0d.hits", tag, e.k), h, e.h);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 0; ml[i] = 0; mc[i] = 0; mh[i] = 0;
        end
    endtask

    // One clock edge on instance k with the given inputs; the model advances in step.
    task automatic step(input string tag, input int k, input logic en, input logic clr,
                        input logic w, input logic [1:0] m);
        int inc;
        drive(k, en, clr, w, m);
        if (clr) begin
            mv[k] = 0; ml[k] = 0; mc[k] = 0; mh[k] = 0;
        end else if (en) begin
            inc = (mv[k] != 0) && (ml[k] == int'(w)) && (mc[k] == RL[k] - 1) &&
                  (allow_m(m, int'(w)) != 0);
            if (mv[k] == 0 || ml[k] != int'(w)) begin
                mv[k] = 1; ml[k] = int'(w); mc[k] = 1;
            end else if (mc[k] < RL[k]) begin
                mc[k] = mc[k] + 1;
            end
            if (inc != 0 && mh[k] < HM[k]) mh[k] = mh[k] + 1;
        end
        push_exp(k);
        @(posedge clk);
        #1;
        pop_cmp(tag);
    endtask

    task automatic check_now(input string tag, input int k);
        push_exp(k);
        #1;
        pop_cmp(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic z;
        logic [7:0] st, rl, h;
        int rlseq[7] = '{1, 2, 3, 1, 2, 3, 4};
        int wseq[7]  = '{0, 0, 0, 1, 1, 1, 1};

        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b0, 2'b00);
        model_reset();
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) check_now("reset", i);
        chk("reset.z_const", 8'(b0.z), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two ones in a row on RUN_LEN=2
        step("t1a", 0, 1'b1, 1'b0, 1'b1, 2'b00);
        get_obs(0, z, st, rl, h);
        chk("t1a.z_low", 8'(z), 8'h00);
        step("t1b", 0, 1'b1, 1'b0, 1'b1, 2'b00);
        get_obs(0, z, st, rl, h);
        chk("t1.z", 8'(z), 8'h01);
        chk("t1.state", st, 8'h0E);
        chk("t1.hits", h, 8'h01);

        // Saturated run stays put
        for (int i = 0; i < 10; i++) step("hold", 0, 1'b1, 1'b0, 1'b1, 2'b00);
        get_obs(0, z, st, rl, h);
        chk("hold.run_len", rl, 8'h02);
        chk("hold.z", 8'(z), 8'h01);
        chk("hold.hits", h, 8'h01);

        // Zeros under ones-only mode, then live mode switch
        step("clr0", 0, 1'b0, 1'b1, 1'b0, 2'b01);
        step("zer1", 0, 1'b1, 1'b0, 1'b0, 2'b01);
        step("zer2", 0, 1'b1, 1'b0, 1'b0, 2'b01);
        get_obs(0, z, st, rl, h);
        chk("ones.z", 8'(z), 8'h00);
        chk("ones.hits", h, 8'h00);
        drive(0, 1'b0, 1'b0, 1'b0, 2'b00);
        check_now("modesw", 0);
        get_obs(0, z, st, rl, h);
        chk("modesw.z", 8'(z), 8'h01);
        chk("modesw.hits", h, 8'h00);
        drive(0, 1'b0, 1'b0, 1'b0, 2'b11);
        check_now("modeoff", 0);
        drive(0, 1'b0, 1'b0, 1'b0, 2'b10);
        check_now("modezero", 0);

        // Clear with en, then freeze with en=0
        step("r1", 0, 1'b1, 1'b0, 1'b1, 2'b00);
        step("r2", 0, 1'b1, 1'b0, 1'b1, 2'b00);
        step("clren", 0, 1'b1, 1'b1, 1'b1, 2'b00);
        get_obs(0, z, st, rl, h);
        chk("clren.state", st, 8'h00);
        chk("clren.hits", h, 8'h00);
        step("s1", 0, 1'b1, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) step("frz", 0, 1'b0, 1'b0, 1'b0, 2'b00);
        get_obs(0, z, st, rl, h);
        chk("frz.state", st, 8'h0D);

        // RUN_LEN=4 sequence
        for (int i = 0; i < 7; i++) begin
            step("rl4", 1, 1'b1, 1'b0, wseq[i][0], 2'b00);
            get_obs(1, z, st, rl, h);
            chk($sformatf("rl4.run_len%0d", i), rl, 8'(rlseq[i]));
            chk($sformatf("rl4.z%0d", i), 8'(z), (i == 6) ? 8'h01 : 8'h00);
        end
        get_obs(1, z, st, rl, h);
        chk("rl4.hits", h, 8'h01);

        // HIT_W=2 saturation over five detections
        for (int i = 0; i < 10; i++) step("sat", 2, 1'b1, 1'b0, ((i / 2) % 2 == 0) ? 1'b1 : 1'b0, 2'b00);
        get_obs(2, z, st, rl, h);
        chk("sat.hits", h, 8'h03);

        // Async reset in the middle of a cycle
        step("pre", 1, 1'b1, 1'b0, 1'b1, 2'b00);
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) check_now("areset", i);
        get_obs(2, z, st, rl, h);
        chk("areset.hits2", h, 8'h00);
        chk("areset.state1", 8'(b1.state), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
